disp_scan_ctrl: RTL and testbench

- Sequences the 7-segment output stage of the SAP-1.
- Accepts an 8-bit value from the output register on a load strobe.
- Converts the value to three BCD digits with a sequential double-dabble engine.
- Time-multiplexes the digits onto one shared BCD-to-segment decoder through one-hot digit selects, so a single decoder drives all digits.

---
 rtl/disp_pkg.sv | 20 ++
 rtl/bin2bcd_seq.sv | 92 +++++++++
 rtl/disp_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_disp_scan_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared definitions for the SAP-1 7-segment output stage.
//   BCD_BLANK  - code the shared decoder renders dark (any code > 9 is dark)
//   conv_state_t - conversion FSM states (IDLE, SHIFT, COMMIT)
//   iter_width - width of the double-dabble iteration counter for a given DATA_W
package disp_pkg;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_t;

  // The counter must be able to hold DATA_W itself, hence DATA_W + 1 values.
  function automatic int iter_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD engine.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - accepted in IDLE and in COMMIT (back-to-back restart)
//   bin_in      - binary value captured when start is accepted
//   done        - high for the single COMMIT cycle; bcd_out is final then
//   bcd_out     - BCD accumulator, nibble 0 is the least significant digit
// A conversion takes DATA_W SHIFT cycles followed by one COMMIT cycle.
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin_in,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd_out
);

  localparam int IW = iter_width(DATA_W);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int SW = BW + DATA_W;

  conv_state_t    state, state_next;
  logic [SW-1:0]  sreg, sreg_next, corrected;
  logic [IW-1:0]  iter, iter_next;

  assign bcd_out = sreg[SW-1 -: BW];

  // Add-3 correction: every BCD nibble that is 5 or more is bumped by 3
  // before the shift, so that the shift carries correctly into the next digit.
  always_comb begin
    corrected = sreg;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sreg[DATA_W + 4*i +: 4] >= 4'd5)
        corrected[DATA_W + 4*i +: 4] = sreg[DATA_W + 4*i +: 4] + 4'd3;
    end
  end

  // Next-state logic. The {bcd,bin} register shifts left so binary bits
  // leave the MSB of the binary field and enter BCD nibble 0. A start seen
  // in COMMIT reloads immediately so queued values lose no cycle.
  always_comb begin
    state_next = state;
    sreg_next  = sreg;
    iter_next  = iter;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          sreg_next  = {{BW{1'b0}}, bin_in};
          iter_next  = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        sreg_next = {corrected[SW-2:0], 1'b0};
        iter_next = iter + 1'b1;
        if (iter == IW'(DATA_W - 1))
          state_next = COMMIT;
      end
      COMMIT: begin
        done = 1'b1;
        if (start) begin
          sreg_next  = {{BW{1'b0}}, bin_in};
          iter_next  = '0;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register for the conversion FSM and its datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      iter  <= '0;
    end else begin
      state <= state_next;
      sreg  <= sreg_next;
      iter  <= iter_next;
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: SAP-1 7-segment output sequencer.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - single-cycle strobe sampling value
//   value      - binary number to display
//   busy       - high while a conversion is in progress
//   digit_bcd  - BCD code of the selected digit, to the shared decoder
//   digit_sel  - one-hot active-high digit enable, bit 0 = least significant
// Optional feature macro: LEAD_ZERO_BLANK_EN - leading zeros above the most
// significant non-zero digit are driven as BCD_BLANK (digit 0 never blanked).
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_DIGITS  = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_W-1:0]     value,
  output logic                  busy,
  output logic [3:0]            digit_bcd,
  output logic [NUM_DIGITS-1:0] digit_sel
);

  localparam int BW   = 4 * NUM_DIGITS;
  localparam int CW   = $clog2(REFRESH_DIV);
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
`ifdef LEAD_ZERO_BLANK_EN
  // Reset display is 0, so every digit above digit 0 starts blanked.
  localparam logic [NUM_DIGITS-1:0] BLANK_RST = ~NUM_DIGITS'(1);
`else
  localparam logic [NUM_DIGITS-1:0] BLANK_RST = '0;
`endif

  logic                  eng_start, eng_done;
  logic [DATA_W-1:0]     eng_bin;
  logic [BW-1:0]         eng_bcd;
  logic                  pend_flag;
  logic [DATA_W-1:0]     pend_val;
  logic [BW-1:0]         disp, disp_next;
  logic [NUM_DIGITS-1:0] blank, blank_next;
  logic [CW-1:0]         refresh_cnt;
  logic [IDXW-1:0]       idx, idx_next;
  logic                  wrap;

  // A new conversion starts on a load when idle, or at COMMIT when either a
  // fresh load arrives (newest value wins) or a pending value is waiting.
  assign eng_start = (load && (!busy || eng_done)) || (eng_done && pend_flag);
  assign eng_bin   = load ? value : pend_val;

  bin2bcd_seq #(
    .DATA_W    (DATA_W),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_engine (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (eng_start),
    .bin_in (eng_bin),
    .done   (eng_done),
    .bcd_out(eng_bcd)
  );

  // busy mirrors the engine being out of IDLE; it only drops at a COMMIT
  // that has nothing queued behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         busy <= 1'b0;
    else if (eng_start) busy <= 1'b1;
    else if (eng_done)  busy <= 1'b0;
  end

  // One-deep pending register. Loads during a conversion overwrite it; it is
  // consumed (or superseded by a simultaneous load) at COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_flag <= 1'b0;
      pend_val  <= '0;
    end else if (eng_done) begin
      pend_flag <= 1'b0;
    end else if (load && busy) begin
      pend_flag <= 1'b1;
      pend_val  <= value;
    end
  end

  // Display digits and blank mask change together, only at COMMIT, so a
  // partially converted number is never visible.
  always_comb begin
    disp_next  = disp;
    blank_next = blank;
    if (eng_done) begin
      disp_next  = eng_bcd;
      blank_next = '0;
`ifdef LEAD_ZERO_BLANK_EN
      begin
        logic all_zero_above;
        all_zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
          all_zero_above = all_zero_above && (eng_bcd[4*i +: 4] == 4'd0);
          blank_next[i]  = all_zero_above;
        end
      end
`endif
    end
  end

  // Scanner index: advances one digit each time the refresh counter wraps.
  always_comb begin
    wrap     = (refresh_cnt == CW'(REFRESH_DIV - 1));
    idx_next = idx;
    if (wrap) begin
      if (idx == IDXW'(NUM_DIGITS - 1)) idx_next = '0;
      else                              idx_next = idx + 1'b1;
    end
  end

  // Scanner and display registers. digit_sel and digit_bcd are both taken
  // from next-state values in the same edge so select and data never skew,
  // and a commit shows up on the very edge it happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      idx         <= '0;
      disp        <= '0;
      blank       <= BLANK_RST;
      digit_sel   <= NUM_DIGITS'(1);
      digit_bcd   <= 4'd0;
    end else begin
      refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
      idx         <= idx_next;
      disp        <= disp_next;
      blank       <= blank_next;
      digit_sel   <= NUM_DIGITS'(1) << idx_next;
      digit_bcd   <= blank_next[idx_next] ? BCD_BLANK : disp_next[4*idx_next +: 4];
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: self-checking bench for disp_scan_ctrl (DATA_W=8,
// NUM_DIGITS=3, REFRESH_DIV=4). Honours LEAD_ZERO_BLANK_EN when defined.
module tb_disp_scan_ctrl;

  localparam int RDIV = 4;
  localparam int LAT  = 9;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       load  = 1'b0;
  logic [7:0] value = 8'd0;
  logic       busy;
  logic [3:0] digit_bcd;
  logic [2:0] digit_sel;

  int tests = 0;
  int fails = 0;

  // Behavioural model: whole numbers and a countdown, no shift register.
  bit mBusy;
  int mRemain;
  int mCur;
  int mShown;
  bit mPend;
  int mPendVal;
  int mEdges;
  int busyRun;

  typedef struct {
    logic [7:0]  val;
    logic [11:0] dig;
    logic [11:0] blk;
  } vec_t;
  vec_t vecs[8];

  disp_scan_ctrl #(
    .DATA_W     (8),
    .NUM_DIGITS (3),
    .REFRESH_DIV(RDIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value    (value),
    .busy     (busy),
    .digit_bcd(digit_bcd),
    .digit_sel(digit_sel)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Hard stop in case something hangs.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int expDigit(input int shown, input int i);
    int p;
    p = (i == 0) ? 1 : (i == 1) ? 10 : 100;
`ifdef LEAD_ZERO_BLANK_EN
    if (i > 0 && shown < p) return 15;
`endif
    return (shown / p) % 10;
  endfunction

  task automatic checkOne(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mBusy = 0; mRemain = 0; mCur = 0; mShown = 0;
    mPend = 0; mPendVal = 0; mEdges = 0;
  endtask

  // One clock edge of the model, given the inputs sampled on that edge.
  task automatic modelEdge(input bit ld, input int v);
    mEdges++;
    if (mBusy) begin
      mRemain--;
      if (mRemain == 0) begin
        mShown = mCur;
        if (ld) begin
          mCur = v; mRemain = LAT; mPend = 0;
        end else if (mPend) begin
          mCur = mPendVal; mRemain = LAT; mPend = 0;
        end else begin
          mBusy = 0;
        end
      end else if (ld) begin
        mPend = 1; mPendVal = v;
      end
    end else if (ld) begin
      mBusy = 1; mCur = v; mRemain = LAT;
    end
  endtask

  task automatic checkOutput();
    int ix;
    ix = (mEdges / RDIV) % 3;
    checkOne("busy", int'(busy), int'(mBusy));
    checkOne("digit_sel", int'(digit_sel), 1 << ix);
    checkOne("digit_bcd", int'(digit_bcd), expDigit(mShown, ix));
  endtask

  task automatic applyStimulus(input bit ld, input logic [7:0] v);
    load  = ld;
    value = v;
    @(posedge clk);
    modelEdge(ld, int'(v));
    #1;
    load = 1'b0;
    if (busy === 1'b1) busyRun++;
    checkOutput();
  endtask

  // Assert reset asynchronously away from the clock edge, check it acts at
  // once, then release it just after the next edge.
  task automatic doReset();
    rst_n = 1'b0;
    #2;
    checkOne("rst_busy", int'(busy), 0);
    checkOne("rst_digit_sel", int'(digit_sel), 1);
    checkOne("rst_digit_bcd", int'(digit_bcd), 0);
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      applyStimulus(1'b0, 8'd0);
      n++;
    end
    checkOne("drain_idle", int'(busy === 1'b1), 0);
  endtask

  initial begin
    vecs[0] = '{8'd255, 12'h255, 12'h255};
    vecs[1] = '{8'd0,   12'h000, 12'hFF0};
    vecs[2] = '{8'd7,   12'h007, 12'hFF7};
    vecs[3] = '{8'd42,  12'h042, 12'hF42};
    vecs[4] = '{8'd100, 12'h100, 12'h100};
    vecs[5] = '{8'd199, 12'h199, 12'h199};
    vecs[6] = '{8'd10,  12'h010, 12'hF10};
    vecs[7] = '{8'd9,   12'h009, 12'hFF9};

    modelReset();
    #1;
    doReset();

    // Idle scan straight after reset.
    repeat (3 * RDIV + 1) applyStimulus(1'b0, 8'd0);

    // Table vectors: load, wait out the conversion, then sweep every digit.
    for (int k = 0; k < 8; k++) begin
      logic [11:0] exp12;
`ifdef LEAD_ZERO_BLANK_EN
      exp12 = vecs[k].blk;
`else
      exp12 = vecs[k].dig;
`endif
      busyRun = 0;
      applyStimulus(1'b1, vecs[k].val);
      repeat (LAT) applyStimulus(1'b0, 8'd0);
      checkOne("vec_busy_len", busyRun, LAT);
      for (int c = 0; c < 3 * RDIV; c++) begin
        int ix;
        applyStimulus(1'b0, 8'd0);
        ix = (mEdges / RDIV) % 3;
        checkOne("vec_digit", int'(digit_bcd), int'(exp12[4*ix +: 4]));
      end
    end

    // Load while busy: 17, then 42 three cycles later, then 99.
    busyRun = 0;
    applyStimulus(1'b1, 8'd17);
    applyStimulus(1'b0, 8'd0);
    applyStimulus(1'b0, 8'd0);
    applyStimulus(1'b1, 8'd42);
    applyStimulus(1'b1, 8'd99);
    drain();
    checkOne("pend_busy_len", busyRun, 18);
    repeat (3 * RDIV) applyStimulus(1'b0, 8'd0);

    // Back-to-back: second load lands exactly on the COMMIT edge.
    busyRun = 0;
    applyStimulus(1'b1, 8'd100);
    repeat (LAT - 1) applyStimulus(1'b0, 8'd0);
    applyStimulus(1'b1, 8'd101);
    drain();
    checkOne("b2b_busy_len", busyRun, 18);
    repeat (3 * RDIV) applyStimulus(1'b0, 8'd0);

    // Reset during SHIFT iteration 4 of 128; nothing stale may commit.
    applyStimulus(1'b1, 8'd128);
    repeat (4) applyStimulus(1'b0, 8'd0);
    doReset();
    busyRun = 0;
    repeat (20) applyStimulus(1'b0, 8'd0);
    checkOne("post_rst_busy", busyRun, 0);

    // Randomized traffic against the model.
    for (int r = 0; r < 500; r++) begin
      bit ld;
      ld = ($urandom_range(0, 4) == 0);
      applyStimulus(ld, 8'($urandom_range(0, 255)));
    end
    drain();
    repeat (3 * RDIV) applyStimulus(1'b0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
